// File: rtl/debugger_rx.sv
// Host-to-board command receiver for the UART debug link: decodes run/step/dump/load
// commands and streams big-endian program words into instruction memory.
module debugger_rx #(
   parameter int         ADDR_WIDTH = 8,
   parameter logic [7:0] CMD_RUN    = 8'h63,
   parameter logic [7:0] CMD_STEP   = 8'h73,
   parameter logic [7:0] CMD_DUMP   = 8'h64,
   parameter logic [7:0] CMD_LOAD   = 8'h6C
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rxUARTEmpty,
   input  logic [7:0]            r_data,
   output logic                  rd_uart,
   input  logic                  dataSent,
   output logic                  sendSignal,
   output logic                  runMode,
   output logic                  stepPulse,
   output logic                  instrWrite,
   output logic [ADDR_WIDTH-1:0] instrAddr,
   output logic [31:0]           instrData,
   output logic                  loadDone,
   output logic                  cmdError,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, LEN, LOAD, DUMP_WAIT} RxState;

   RxState                state, stateNext;
   logic                  runModeNext, sendSignalNext, stepPulseNext;
   logic                  instrWriteNext, loadDoneNext, cmdErrorNext;
   logic [ADDR_WIDTH-1:0] instrAddrNext, wordAddr, wordAddrNext;
   logic [31:0]           instrDataNext;
   logic [1:0]            byteCnt, byteCntNext;
   logic [7:0]            wordsLeft, wordsLeftNext;
   logic [23:0]           shiftReg, shiftRegNext;

   // All registered state, including the one-cycle strobes, advances together here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         runMode    <= 1'b0;
         sendSignal <= 1'b0;
         stepPulse  <= 1'b0;
         instrWrite <= 1'b0;
         instrAddr  <= '0;
         instrData  <= '0;
         loadDone   <= 1'b0;
         cmdError   <= 1'b0;
         wordAddr   <= '0;
         byteCnt    <= '0;
         wordsLeft  <= '0;
         shiftReg   <= '0;
      end else begin
         state      <= stateNext;
         runMode    <= runModeNext;
         sendSignal <= sendSignalNext;
         stepPulse  <= stepPulseNext;
         instrWrite <= instrWriteNext;
         instrAddr  <= instrAddrNext;
         instrData  <= instrDataNext;
         loadDone   <= loadDoneNext;
         cmdError   <= cmdErrorNext;
         wordAddr   <= wordAddrNext;
         byteCnt    <= byteCntNext;
         wordsLeft  <= wordsLeftNext;
         shiftReg   <= shiftRegNext;
      end
   end

   // Decode the byte being popped this cycle; strobes default low, everything else holds.
   always_comb begin
      stateNext      = state;
      runModeNext    = runMode;
      sendSignalNext = sendSignal;
      stepPulseNext  = 1'b0;
      instrWriteNext = 1'b0;
      instrAddrNext  = instrAddr;
      instrDataNext  = instrData;
      loadDoneNext   = 1'b0;
      cmdErrorNext   = 1'b0;
      wordAddrNext   = wordAddr;
      byteCntNext    = byteCnt;
      wordsLeftNext  = wordsLeft;
      shiftRegNext   = shiftReg;
      rd_uart        = ((state == IDLE) || (state == LEN) || (state == LOAD)) && !rxUARTEmpty;
      busy           = (state != IDLE);

      case (state)
         IDLE: begin
            if (rd_uart) begin
               case (r_data)
                  CMD_RUN:  runModeNext = 1'b1;
                  CMD_STEP: begin
                     runModeNext   = 1'b0;
                     stepPulseNext = 1'b1;
                  end
                  CMD_DUMP: begin
                     sendSignalNext = 1'b1;
                     stateNext      = DUMP_WAIT;
                  end
                  CMD_LOAD: begin
                     runModeNext = 1'b0;
                     stateNext   = LEN;
                  end
                  default:  cmdErrorNext = 1'b1;
               endcase
            end
         end
         LEN: begin
            if (rd_uart) begin
               if (r_data == 8'd0) begin
                  loadDoneNext = 1'b1;
                  stateNext    = IDLE;
               end else begin
                  wordsLeftNext = r_data;
                  wordAddrNext  = '0;
                  byteCntNext   = '0;
                  stateNext     = LOAD;
               end
            end
         end
         LOAD: begin
            // The fourth byte completes the word directly from r_data, so popping never pauses.
            if (rd_uart) begin
               if (byteCnt == 2'd3) begin
                  instrWriteNext = 1'b1;
                  instrDataNext  = {shiftReg, r_data};
                  instrAddrNext  = wordAddr;
                  wordAddrNext   = wordAddr + ADDR_WIDTH'(1);
                  wordsLeftNext  = wordsLeft - 8'd1;
                  byteCntNext    = 2'd0;
                  if (wordsLeft == 8'd1) begin
                     loadDoneNext = 1'b1;
                     stateNext    = IDLE;
                  end
               end else begin
                  shiftRegNext = {shiftReg[15:0], r_data};
                  byteCntNext  = byteCnt + 2'd1;
               end
            end
         end
         DUMP_WAIT: begin
            if (dataSent) begin
               sendSignalNext = 1'b0;
               stateNext      = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_debugger_rx.sv
// Directed self-checking bench for debugger_rx, with a behavioural RX FIFO feeding the DUT.
module tb_debugger_rx;

   logic        clk;
   logic        reset;
   logic        rxUARTEmpty;
   logic [7:0]  r_data;
   logic        rd_uart;
   logic        dataSent;
   logic        sendSignal;
   logic        runMode;
   logic        stepPulse;
   logic        instrWrite;
   logic [7:0]  instrAddr;
   logic [31:0] instrData;
   logic        loadDone;
   logic        cmdError;
   logic        busy;

   logic [7:0]  fifo[$];
   int          errors = 0;
   int          checks = 0;

   debugger_rx dut (
      .clk(clk), .reset(reset), .rxUARTEmpty(rxUARTEmpty), .r_data(r_data),
      .rd_uart(rd_uart), .dataSent(dataSent), .sendSignal(sendSignal),
      .runMode(runMode), .stepPulse(stepPulse), .instrWrite(instrWrite),
      .instrAddr(instrAddr), .instrData(instrData), .loadDone(loadDone),
      .cmdError(cmdError), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic refreshFifo();
      rxUARTEmpty = (fifo.size() == 0);
      r_data      = (fifo.size() != 0) ? fifo[0] : 8'h00;
   endtask

   task automatic pushByte(input logic [7:0] b);
      fifo.push_back(b);
      refreshFifo();
   endtask

   // Advance one clock; the FIFO head moves only if the DUT popped at that edge.
   task automatic cycle();
      logic       wasPop;
      logic [7:0] dropped;
      wasPop = rd_uart;
      @(negedge clk);
      if (wasPop && fifo.size() != 0) dropped = fifo.pop_front();
      refreshFifo();
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      dataSent = 1'b0;
      refreshFifo();
      cycle();
      cycle();
      checks++;
      if ({rd_uart, sendSignal, runMode, stepPulse, instrWrite, loadDone, cmdError, busy} !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 00000000",
                  {rd_uart, sendSignal, runMode, stepPulse, instrWrite, loadDone, cmdError, busy});
      end
      checks++;
      if (instrAddr !== 8'h00 || instrData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_bus: got addr=%h data=%h expected 00/00000000", instrAddr, instrData);
      end
      reset = 1'b0;
      cycle();
   endtask

   task automatic test_run_step();
      pushByte(8'h63);
      pushByte(8'h73);
      #1;
      checks++;
      if (rd_uart !== 1'b1) begin
         errors++;
         $display("[TB] FAIL run_pop0: got rd_uart=%b expected 1", rd_uart);
      end
      cycle();
      checks++;
      if ({runMode, stepPulse, rd_uart} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL run_set: got run/step/rd=%b expected 101", {runMode, stepPulse, rd_uart});
      end
      cycle();
      checks++;
      if ({runMode, stepPulse, rd_uart} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL step_pulse: got run/step/rd=%b expected 010", {runMode, stepPulse, rd_uart});
      end
      cycle();
      checks++;
      if (stepPulse !== 1'b0) begin
         errors++;
         $display("[TB] FAIL step_width: got stepPulse=%b expected 0", stepPulse);
      end
   endtask

   task automatic test_load_stream();
      logic [7:0]  bytes [10] = '{8'h6C, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      int          pops = 0, nW = 0, doneCount = 0, doneCycle = -1;
      int          wCycle [2] = '{-1, -1};
      logic [7:0]  wAddr [2] = '{8'hxx, 8'hxx};
      logic [31:0] wData [2] = '{32'hx, 32'hx};
      foreach (bytes[i]) pushByte(bytes[i]);
      #1;
      for (int i = 0; i < 12; i++) begin
         if (rd_uart) pops++;
         if (instrWrite) begin
            if (nW < 2) begin
               wCycle[nW] = i;
               wAddr[nW]  = instrAddr;
               wData[nW]  = instrData;
            end
            nW++;
         end
         if (loadDone) begin
            doneCount++;
            doneCycle = i;
         end
         cycle();
      end
      checks++;
      if (pops !== 10 || nW !== 2) begin
         errors++;
         $display("[TB] FAIL stream_counts: got pops=%0d writes=%0d expected 10/2", pops, nW);
      end
      checks++;
      if (wCycle[0] !== 6 || wAddr[0] !== 8'h00 || wData[0] !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL stream_word0: got cyc=%0d addr=%h data=%h expected 6/00/12345678",
                  wCycle[0], wAddr[0], wData[0]);
      end
      checks++;
      if (wCycle[1] !== 10 || wAddr[1] !== 8'h01 || wData[1] !== 32'h9ABCDEF0) begin
         errors++;
         $display("[TB] FAIL stream_word1: got cyc=%0d addr=%h data=%h expected 10/01/9abcdef0",
                  wCycle[1], wAddr[1], wData[1]);
      end
      checks++;
      if (doneCount !== 1 || doneCycle !== 10) begin
         errors++;
         $display("[TB] FAIL stream_done: got count=%0d cyc=%0d expected 1/10", doneCount, doneCycle);
      end
      checks++;
      if (busy !== 1'b0 || instrAddr !== 8'h01 || instrData !== 32'h9ABCDEF0) begin
         errors++;
         $display("[TB] FAIL stream_hold: got busy=%b addr=%h data=%h expected 0/01/9abcdef0",
                  busy, instrAddr, instrData);
      end
   endtask

   task automatic test_load_stall();
      int pops = 0, nW = 0, wCycle = -1, doneCycle = -1;
      logic [7:0]  wAddr = 8'hxx;
      logic [31:0] wData = 32'hx;
      pushByte(8'h6C);
      pushByte(8'h01);
      pushByte(8'hAA);
      pushByte(8'hBB);
      #1;
      for (int i = 0; i < 24; i++) begin
         if (rd_uart) pops++;
         if (instrWrite) nW++;
         cycle();
      end
      checks++;
      if (pops !== 4 || nW !== 0 || busy !== 1'b1 || rd_uart !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_hold: got pops=%0d writes=%0d busy=%b rd=%b expected 4/0/1/0",
                  pops, nW, busy, rd_uart);
      end
      pushByte(8'hCC);
      pushByte(8'hDD);
      #1;
      for (int j = 0; j < 5; j++) begin
         if (instrWrite) begin
            nW++;
            wCycle = j;
            wAddr  = instrAddr;
            wData  = instrData;
         end
         if (loadDone) doneCycle = j;
         cycle();
      end
      checks++;
      if (nW !== 1 || wCycle !== 2 || wAddr !== 8'h00 || wData !== 32'hAABBCCDD || doneCycle !== 2) begin
         errors++;
         $display("[TB] FAIL stall_resume: got n=%0d cyc=%0d addr=%h data=%h done=%0d expected 1/2/00/aabbccdd/2",
                  nW, wCycle, wAddr, wData, doneCycle);
      end
   endtask

   task automatic test_dump();
      pushByte(8'h64);
      pushByte(8'h63);
      #1;
      cycle();
      checks++;
      if ({sendSignal, rd_uart, busy} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL dump_enter: got send/rd/busy=%b expected 101", {sendSignal, rd_uart, busy});
      end
      repeat (4) cycle();
      checks++;
      if (fifo.size() !== 1 || sendSignal !== 1'b1 || rd_uart !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dump_wait: got queued=%0d send=%b rd=%b expected 1/1/0",
                  fifo.size(), sendSignal, rd_uart);
      end
      dataSent = 1'b1;
      cycle();
      dataSent = 1'b0;
      checks++;
      if ({sendSignal, runMode, rd_uart} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL dump_release: got send/run/rd=%b expected 001", {sendSignal, runMode, rd_uart});
      end
      cycle();
      checks++;
      if (runMode !== 1'b1 || fifo.size() !== 0) begin
         errors++;
         $display("[TB] FAIL dump_then_run: got run=%b queued=%0d expected 1/0", runMode, fifo.size());
      end
   endtask

   task automatic test_error_and_empty_load();
      int nW = 0, doneCycle = -1;
      pushByte(8'h55);
      #1;
      cycle();
      checks++;
      if ({cmdError, runMode, sendSignal, stepPulse, instrWrite, loadDone, busy} !== 7'b1100000 ||
          instrAddr !== 8'h00 || instrData !== 32'hAABBCCDD) begin
         errors++;
         $display("[TB] FAIL bad_cmd: got flags=%b addr=%h data=%h expected 1100000/00/aabbccdd",
                  {cmdError, runMode, sendSignal, stepPulse, instrWrite, loadDone, busy}, instrAddr, instrData);
      end
      cycle();
      checks++;
      if (cmdError !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bad_cmd_width: got cmdError=%b expected 0", cmdError);
      end
      pushByte(8'h6C);
      pushByte(8'h00);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (instrWrite) nW++;
         if (loadDone) doneCycle = i;
         cycle();
      end
      checks++;
      if (nW !== 0 || doneCycle !== 2 || busy !== 1'b0 || runMode !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_load: got writes=%0d done=%0d busy=%b run=%b expected 0/2/0/0",
                  nW, doneCycle, busy, runMode);
      end
   endtask

   task automatic test_reset_midload();
      pushByte(8'h6C);
      pushByte(8'h01);
      pushByte(8'h11);
      pushByte(8'h22);
      #1;
      repeat (4) cycle();
      checks++;
      if (busy !== 1'b1 || rd_uart !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midload_stall: got busy=%b rd=%b expected 1/0", busy, rd_uart);
      end
      reset = 1'b1;
      cycle();
      checks++;
      if ({rd_uart, sendSignal, runMode, stepPulse, instrWrite, loadDone, cmdError, busy} !== 8'h00 ||
          instrAddr !== 8'h00 || instrData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midload_reset: got flags=%b addr=%h data=%h expected 00000000/00/00000000",
                  {rd_uart, sendSignal, runMode, stepPulse, instrWrite, loadDone, cmdError, busy},
                  instrAddr, instrData);
      end
      reset = 1'b0;
      pushByte(8'h63);
      #1;
      cycle();
      checks++;
      if ({runMode, busy, instrWrite, loadDone} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL after_reset_run: got run/busy/wr/done=%b expected 1000",
                  {runMode, busy, instrWrite, loadDone});
      end
   endtask

   initial begin
      reset    = 1'b1;
      dataSent = 1'b0;
      refreshFifo();
      test_reset();
      test_run_step();
      test_load_stream();
      test_load_stall();
      test_dump();
      test_error_and_empty_load();
      test_reset_midload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
